// File: rtl/rtc_bus_ctrl_pkg.sv
// RTC bus controller shared definitions: state encoding,
// default phase timings, bus widths and the per-state drive table.
package rtc_bus_ctrl_pkg;

    localparam int DIR_W  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam int T_SET_DEF = 2;
    localparam int T_PUL_DEF = 10;
    localparam int T_HLD_DEF = 2;
    localparam int T_GAP_DEF = 4;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_A_SET = 4'd1,
        S_A_PUL = 4'd2,
        S_A_HLD = 4'd3,
        S_GAP   = 4'd4,
        S_D_SET = 4'd5,
        S_D_PUL = 4'd6,
        S_D_HLD = 4'd7,
        S_DONE  = 4'd8
    } state_e;

    typedef struct packed {
        logic              stw;
        logic [DIR_W-1:0]  dir;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic              busy;
        logic              frw;
        logic              ad_oe;
        logic              ad_sel;
        logic              cs_n;
        logic              wr_n;
        logic              rd_n;
        logic [DATA_W-1:0] ad_out;
    } bus_out_t;

    localparam bus_out_t BUS_IDLE = '{
        busy:   1'b0,
        frw:    1'b0,
        ad_oe:  1'b0,
        ad_sel: 1'b0,
        cs_n:   1'b1,
        wr_n:   1'b1,
        rd_n:   1'b1,
        ad_out: '0
    };

    // Pin values that belong to a given state and latched request.
    function automatic bus_out_t bus_drive(input state_e s, input req_t r);
        bus_out_t o;
        o      = BUS_IDLE;
        o.busy = (s != S_IDLE);
        unique case (s)
            S_A_SET, S_A_HLD, S_GAP: begin
                o.ad_oe  = 1'b1;
                o.ad_out = r.dir;
            end
            S_A_PUL: begin
                o.ad_oe  = 1'b1;
                o.ad_out = r.dir;
                o.cs_n   = 1'b0;
                o.wr_n   = 1'b0;
            end
            S_D_SET, S_D_HLD: begin
                o.ad_sel = 1'b1;
                if (r.stw) begin
                    o.ad_oe  = 1'b1;
                    o.ad_out = r.data;
                end
            end
            S_D_PUL: begin
                o.ad_sel = 1'b1;
                o.cs_n   = 1'b0;
                if (r.stw) begin
                    o.ad_oe  = 1'b1;
                    o.ad_out = r.data;
                    o.wr_n   = 1'b0;
                end else begin
                    o.rd_n = 1'b0;
                end
            end
            S_DONE: begin
                o.frw = 1'b1;
            end
            default: begin
                o.busy = 1'b0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Phase timer: down-counter reloaded on each state entry,
// flags the last cycle of the current phase.
module rtc_phase_timer
    import rtc_bus_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on entry, otherwise count down and park at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC bus controller: runs one timed address/data cycle on the
// multiplexed RTC bus per menu request and pulses FRW when done.
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int T_SET = T_SET_DEF,
    parameter int T_PUL = T_PUL_DEF,
    parameter int T_HLD = T_HLD_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Acceso,
    input  logic              STW,
    input  logic [DIR_W-1:0]  Dir,
    input  logic [DATA_W-1:0] Data_wr,
    output logic [DATA_W-1:0] Data_rd,
    output logic              FRW,
    output logic              Busy,
    output logic [DATA_W-1:0] AD_out,
    output logic              AD_oe,
    input  logic [DATA_W-1:0] AD_in,
    output logic              AD_sel,
    output logic              CS_n,
    output logic              WR_n,
    output logic              RD_n
);

    state_e           r_state;
    state_e           w_state_nxt;
    req_t             r_req;
    req_t             w_req_nxt;
    bus_out_t         r_out;
    bus_out_t         w_out_nxt;
    logic [DATA_W-1:0] r_data_rd;
    logic             w_accept;
    logic             w_zero;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_rd_capture;

    assign w_accept = (r_state == S_IDLE) && Acceso;

    // Request fields are captured only when a new access is accepted.
    always_comb begin
        w_req_nxt = r_req;
        if (w_accept) begin
            w_req_nxt.stw  = STW;
            w_req_nxt.dir  = Dir;
            w_req_nxt.data = Data_wr;
        end
    end

    // Next state: timed phases advance when the timer hits zero.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (Acceso) w_state_nxt = S_A_SET;
            S_A_SET: if (w_zero) w_state_nxt = S_A_PUL;
            S_A_PUL: if (w_zero) w_state_nxt = S_A_HLD;
            S_A_HLD: if (w_zero) w_state_nxt = S_GAP;
            S_GAP:   if (w_zero) w_state_nxt = S_D_SET;
            S_D_SET: if (w_zero) w_state_nxt = S_D_PUL;
            S_D_PUL: if (w_zero) w_state_nxt = S_D_HLD;
            S_D_HLD: if (w_zero) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Timer reload value for the phase being entered.
    always_comb begin
        w_load_val = '0;
        unique case (w_state_nxt)
            S_A_SET, S_D_SET: w_load_val = CNT_W'(T_SET - 1);
            S_A_PUL, S_D_PUL: w_load_val = CNT_W'(T_PUL - 1);
            S_A_HLD, S_D_HLD: w_load_val = CNT_W'(T_HLD - 1);
            S_GAP:            w_load_val = CNT_W'(T_GAP - 1);
            default:          w_load_val = '0;
        endcase
    end

    assign w_load    = (w_state_nxt != r_state);
    assign w_out_nxt = bus_drive(w_state_nxt, w_req_nxt);

    assign w_rd_capture = (r_state == S_D_PUL) && w_zero && !r_req.stw;

    rtc_phase_timer u_timer (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // State and latched request registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
        end
    end

    // Pins are registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out <= BUS_IDLE;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    // Read data is sampled at the edge closing the read strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data_rd <= '0;
        end else if (w_rd_capture) begin
            r_data_rd <= AD_in;
        end
    end

    assign Data_rd = r_data_rd;
    assign FRW     = r_out.frw;
    assign Busy    = r_out.busy;
    assign AD_out  = r_out.ad_out;
    assign AD_oe   = r_out.ad_oe;
    assign AD_sel  = r_out.ad_sel;
    assign CS_n    = r_out.cs_n;
    assign WR_n    = r_out.wr_n;
    assign RD_n    = r_out.rd_n;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: timeline reference model of the RTC
// access cycle, randomized requests and directed scenarios.
module tb_rtc_bus_ctrl;

    localparam int TS = 2;
    localparam int TP = 10;
    localparam int TH = 2;
    localparam int TG = 4;

    localparam int E_ASET = TS;
    localparam int E_APUL = E_ASET + TP;
    localparam int E_AHLD = E_APUL + TH;
    localparam int E_GAP  = E_AHLD + TG;
    localparam int E_DSET = E_GAP + TS;
    localparam int E_DPUL = E_DSET + TP;
    localparam int E_DHLD = E_DPUL + TH;
    localparam int T_DONE = E_DHLD;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Acceso = 1'b0;
    logic       STW = 1'b0;
    logic [7:0] Dir = '0;
    logic [7:0] Data_wr = '0;
    logic [7:0] Data_rd;
    logic       FRW;
    logic       Busy;
    logic [7:0] AD_out;
    logic       AD_oe;
    logic [7:0] AD_in = '0;
    logic       AD_sel;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;

    int vectors = 0;
    int miscompares = 0;

    int         m_t = -1;
    logic       m_stw = 1'b0;
    logic [7:0] m_dir = '0;
    logic [7:0] m_dat = '0;
    logic [7:0] m_rd = '0;
    logic [7:0] rtc_val = '0;

    always #5 CLK = ~CLK;

    rtc_bus_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .Acceso  (Acceso),
        .STW     (STW),
        .Dir     (Dir),
        .Data_wr (Data_wr),
        .Data_rd (Data_rd),
        .FRW     (FRW),
        .Busy    (Busy),
        .AD_out  (AD_out),
        .AD_oe   (AD_oe),
        .AD_in   (AD_in),
        .AD_sel  (AD_sel),
        .CS_n    (CS_n),
        .WR_n    (WR_n),
        .RD_n    (RD_n)
    );

    // Reference: position in the transaction timeline, -1 when idle.
    always @(posedge CLK) begin
        if (RST) begin
            m_t  = -1;
            m_rd = '0;
        end else if (m_t < 0) begin
            if (Acceso) begin
                m_t   = 0;
                m_stw = STW;
                m_dir = Dir;
                m_dat = Data_wr;
            end
        end else begin
            if (m_t == E_DPUL - 1 && !m_stw) m_rd = AD_in;
            m_t = (m_t == T_DONE) ? -1 : m_t + 1;
        end
    end

    // RTC device: drives its data only while the read strobe is low.
    always @(negedge CLK) begin
        if (m_t >= E_DSET && m_t < E_DPUL) AD_in = rtc_val;
        else AD_in = 8'($urandom);
    end

    function automatic logic [22:0] obs_vec();
        return {Busy, FRW, AD_oe, AD_sel, CS_n, WR_n, RD_n, AD_out, Data_rd};
    endfunction

    function automatic logic [22:0] exp_vec();
        int t = m_t;
        logic a_rng, gap, d_rng, apul, dpul;
        logic oe;
        logic [7:0] out;
        a_rng = (t >= 0) && (t < E_AHLD);
        gap   = (t >= E_AHLD) && (t < E_GAP);
        d_rng = (t >= E_GAP) && (t < E_DHLD);
        apul  = (t >= E_ASET) && (t < E_APUL);
        dpul  = (t >= E_DSET) && (t < E_DPUL);
        oe    = a_rng || gap || (d_rng && m_stw);
        out   = (a_rng || gap) ? m_dir : ((d_rng && m_stw) ? m_dat : 8'h00);
        return {t >= 0, t == T_DONE, oe, d_rng,
                !(apul || dpul), !(apul || (dpul && m_stw)),
                !(dpul && !m_stw), out, m_rd};
    endfunction

    function automatic logic [22:0] care_vec();
        int t = m_t;
        logic sel_c, out_c;
        sel_c = (t < 0) || (t < E_AHLD) || (t >= E_GAP && t < E_DHLD);
        out_c = (t < 0) || (t < E_GAP) ||
                (t >= E_GAP && t < E_DHLD && m_stw);
        return {4'b1110 | {3'b000, sel_c}, 3'b111, {8{out_c}}, 8'hFF};
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        Acceso = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
        end
    endtask

    task automatic test_write();
        int apul = 0, dpul = 0, rdl = 0, frw_n = 0, frw_at = -1;
        STW = 1'b1;
        Dir = 8'h44;
        Data_wr = 8'h21;
        Acceso = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i == 0) Acceso = 1'b0;
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL write cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            if (!CS_n && !WR_n && !AD_sel && AD_out == 8'h44) apul++;
            if (!CS_n && !WR_n && AD_sel && AD_out == 8'h21) dpul++;
            if (!RD_n) rdl++;
            if (FRW) begin
                frw_n++;
                frw_at = i;
            end
        end
        vectors += 4;
        if (apul != TP) begin
            miscompares++;
            $display("FAIL write_apul: got %0d want %0d", apul, TP);
        end
        if (dpul != TP) begin
            miscompares++;
            $display("FAIL write_dpul: got %0d want %0d", dpul, TP);
        end
        if (frw_n != 1 || frw_at != T_DONE) begin
            miscompares++;
            $display("FAIL write_frw: got n=%0d at %0d want n=1 at %0d",
                     frw_n, frw_at, T_DONE);
        end
        if (rdl != 0) begin
            miscompares++;
            $display("FAIL write_rdn: got %0d low cycles want 0", rdl);
        end
    endtask

    task automatic test_read();
        int rdp = 0, wrl = 0, oe_bad = 0, frw_at = -1;
        STW = 1'b0;
        Dir = 8'h41;
        Data_wr = 8'($urandom);
        rtc_val = 8'h59;
        Acceso = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i == 0) Acceso = 1'b0;
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL read cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            if (i >= E_GAP && i < E_DHLD && AD_oe) oe_bad++;
            if (!CS_n && !RD_n) rdp++;
            if (!WR_n && i >= E_GAP) wrl++;
            if (FRW) frw_at = i;
        end
        vectors += 4;
        if (Data_rd !== 8'h59) begin
            miscompares++;
            $display("FAIL read_data: got %h want 59", Data_rd);
        end
        if (oe_bad != 0 || rdp != TP) begin
            miscompares++;
            $display("FAIL read_phase: got oe=%0d rd=%0d want 0 and %0d",
                     oe_bad, rdp, TP);
        end
        if (wrl != 0) begin
            miscompares++;
            $display("FAIL read_wrn: got %0d want 0", wrl);
        end
        if (frw_at != T_DONE) begin
            miscompares++;
            $display("FAIL read_frw: got %0d want %0d", frw_at, T_DONE);
        end
    endtask

    task automatic test_busy_ignore();
        int frw_n = 0;
        logic [7:0] d0;
        d0 = 8'($urandom_range(8'h20, 8'hFF));
        STW = 1'b1;
        Dir = d0;
        Data_wr = 8'($urandom);
        Acceso = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL busy cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            if (i >= 3 && i < 26) begin
                Acceso = i[0];
                Dir = 8'h10;
            end else begin
                Acceso = 1'b0;
            end
            vectors++;
            if (!CS_n && !AD_sel && AD_out !== d0) begin
                miscompares++;
                $display("FAIL busy_addr: got %h want %h", AD_out, d0);
            end
            if (FRW) frw_n++;
        end
        vectors++;
        if (frw_n != 1) begin
            miscompares++;
            $display("FAIL busy_frw: got %0d pulses want 1", frw_n);
        end
    endtask

    task automatic test_reset_mid();
        int frw_n = 0;
        STW = 1'b1;
        Dir = 8'($urandom);
        Data_wr = 8'($urandom);
        Acceso = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            if (i == 0) Acceso = 1'b0;
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL rstmid cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            if (i == E_DSET + 4) RST = 1'b1;
            if (i == E_DSET + 5) begin
                RST = 1'b0;
                vectors++;
                if ({CS_n, WR_n, AD_oe, Busy, FRW} !== 5'b11000) begin
                    miscompares++;
                    $display("FAIL rstmid_pins: got %b want 11000",
                             {CS_n, WR_n, AD_oe, Busy, FRW});
                end
            end
            if (FRW) frw_n++;
        end
        vectors++;
        if (frw_n != 0) begin
            miscompares++;
            $display("FAIL rstmid_frw: got %0d want 0", frw_n);
        end
        frw_n = 0;
        Dir = 8'($urandom);
        Data_wr = 8'($urandom);
        Acceso = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i == 0) Acceso = 1'b0;
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL rstmid_next cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            if (FRW) frw_n++;
        end
        vectors++;
        if (frw_n != 1) begin
            miscompares++;
            $display("FAIL rstmid_next_frw: got %0d want 1", frw_n);
        end
    endtask

    task automatic test_back_to_back();
        int frw_n = 0;
        int t_frw[3];
        logic p_sel, p_low;
        logic [7:0] p_out;
        p_sel = AD_sel;
        p_out = AD_out;
        p_low = 1'b0;
        rtc_val = 8'($urandom);
        Acceso = 1'b1;
        for (int i = 0; i < 112; i++) begin
            STW = 1'($urandom);
            Dir = 8'($urandom);
            Data_wr = 8'($urandom);
            @(negedge CLK);
            vectors++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                miscompares++;
                $display("FAIL b2b cyc %0d: got %h want %h", i,
                         obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            vectors++;
            if ((!WR_n && !RD_n) ||
                ((p_low || !CS_n || !WR_n || !RD_n) &&
                 (AD_sel !== p_sel || AD_out !== p_out))) begin
                miscompares++;
                $display("FAIL b2b_order cyc %0d: got sel=%b out=%h wr=%b rd=%b",
                         i, AD_sel, AD_out, WR_n, RD_n);
            end
            p_sel = AD_sel;
            p_out = AD_out;
            p_low = !CS_n || !WR_n || !RD_n;
            if (FRW) begin
                if (frw_n < 3) t_frw[frw_n] = i;
                frw_n++;
                if (frw_n == 3) Acceso = 1'b0;
            end
        end
        vectors += 2;
        if (frw_n != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 3", frw_n);
        end else if (t_frw[1] - t_frw[0] != T_DONE + 2 ||
                     t_frw[2] - t_frw[1] != T_DONE + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d",
                     t_frw[1] - t_frw[0], t_frw[2] - t_frw[1], T_DONE + 2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            STW = 1'($urandom);
            Dir = 8'($urandom);
            Data_wr = 8'($urandom);
            rtc_val = 8'($urandom);
            Acceso = 1'b1;
            for (int i = 0; i < 34 + int'($urandom_range(0, 3)); i++) begin
                @(negedge CLK);
                if (i == 0) Acceso = 1'b0;
                vectors++;
                if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                    miscompares++;
                    $display("FAIL random txn %0d cyc %0d: got %h want %h", n, i,
                             obs_vec() & care_vec(), exp_vec() & care_vec());
                end
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
